// File: rtl/str_window_pkg.sv
// Shared definitions for the bloom-filter string front end.
// The window type matches the data layout the crc hash units expect.
package str_window_pkg;

    localparam int DEF_BYTE_W   = 8;
    localparam int DEF_STR_SIZE = 6;
    localparam int DEF_CNT_W    = 16;

    // [0] is the oldest byte, [STR_SIZE-1] the newest.
    typedef logic [DEF_STR_SIZE-1:0][DEF_BYTE_W-1:0] str_window_t;

endpackage

// File: rtl/str_window.sv
// Turns a sop/eop framed byte stream into every STR_SIZE-byte sliding window
// of each string, one valid/ready handshake per window.
module str_window
    import str_window_pkg::*;
#(
    parameter int BYTE_W   = DEF_BYTE_W,
    parameter int STR_SIZE = DEF_STR_SIZE,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [BYTE_W-1:0]                data_i,
    input  logic                             valid_i,
    input  logic                             sop_i,
    input  logic                             eop_i,
    output logic                             ready_o,
    output logic [STR_SIZE-1:0][BYTE_W-1:0]  win_o,
    output logic                             win_valid_o,
    input  logic                             win_ready_i,
    output logic                             win_last_o,
    output logic [CNT_W-1:0]                 short_cnt_o
);

    localparam int CNT_BITS = $clog2(STR_SIZE + 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM
    } state_t;

    state_t              state, state_next;
    logic [CNT_BITS-1:0] cnt, cnt_next, cnt_plus;
    logic                accept;
    logic                produce;
    logic                last;
    logic                short_inc;

    assign ready_o  = !win_valid_o || win_ready_i;
    assign accept   = valid_i && ready_o;
    assign cnt_plus = cnt + 1'b1;

    // Only cnt decides when a window is complete, so the shift register
    // never needs clearing between strings.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        produce    = 1'b0;
        last       = 1'b0;
        short_inc  = 1'b0;
        if (sop_i) begin
            cnt_next = CNT_BITS'(1);
            if (STR_SIZE == 1) begin
                produce = 1'b1;
                if (eop_i) begin
                    last       = 1'b1;
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    state_next = STREAM;
                end
            end else if (eop_i) begin
                short_inc  = 1'b1;
                state_next = IDLE;
                cnt_next   = '0;
            end else begin
                state_next = FILL;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                FILL: begin
                    cnt_next = cnt_plus;
                    if (cnt_plus == CNT_BITS'(STR_SIZE)) begin
                        produce = 1'b1;
                        if (eop_i) begin
                            last       = 1'b1;
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else begin
                            state_next = STREAM;
                        end
                    end else if (eop_i) begin
                        short_inc  = 1'b1;
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end
                STREAM: begin
                    produce = 1'b1;
                    if (eop_i) begin
                        last       = 1'b1;
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (accept) begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Window shifts toward [0]; discarded bytes shift too, harmlessly.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win_o       <= '0;
            win_valid_o <= 1'b0;
            win_last_o  <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < STR_SIZE - 1; i++) begin
                win_o[i] <= win_o[i+1];
            end
            win_o[STR_SIZE-1] <= data_i;
            win_valid_o       <= produce;
            win_last_o        <= last;
        end else if (win_valid_o && win_ready_i) begin
            win_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            short_cnt_o <= '0;
        end else if (accept && short_inc && (short_cnt_o != {CNT_W{1'b1}})) begin
            short_cnt_o <= short_cnt_o + 1'b1;
        end
    end

endmodule

// File: doc/str_window.md
Name: str_window

Overview:
- Upstream feeder for the combinational crc hash units of the bloom filter.
- Accepts a packetised byte stream (sop/eop framed strings) and presents every STR_SIZE-byte sliding window of each string as a parallel word, matching the crc data_i layout.
- One output handshake per window. Strings shorter than STR_SIZE produce no window and are counted.

Parameters:
BYTE_W, 8, bits per byte
STR_SIZE, 6, window length in bytes (>=1)
CNT_W, 16, width of short-string counter

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
data_i  in  BYTE_W  input byte
valid_i  in  1  input byte valid
sop_i  in  1  first byte of string (qualified by valid_i)
eop_i  in  1  last byte of string (qualified by valid_i)
ready_o  out  1  input ready
win_o  out  STR_SIZE*BYTE_W (packed [STR_SIZE-1:0][BYTE_W-1:0])  window; [0] oldest byte, [STR_SIZE-1] newest
win_valid_o  out  1  window valid
win_ready_i  in  1  downstream ready
win_last_o  out  1  window contains the string's eop byte
short_cnt_o  out  CNT_W  count of strings ended before STR_SIZE bytes, saturating

Behaviour:
- Interface fixed: single clock clk_i; rst_i asynchronous, active-high.
- Reset values: win_o=0, win_valid_o=0, win_last_o=0, short_cnt_o=0, fill count=0, state=IDLE.
- Handshake:
  - ready_o = !win_valid_o || win_ready_i (combinational; ready_o=1 during and after reset).
  - Byte accepted when valid_i && ready_o.
  - Window transfer when win_valid_o && win_ready_i.
- Shift on accept: window shifts toward [0]; the new byte is written to [STR_SIZE-1]. The oldest byte drops out.
- Latency: a byte accepted in cycle N appears in win_o in cycle N+1.
- win_valid_o / win_last_o updates:
  - win_valid_o rises in cycle N+1 if the accept completed a full window.
  - A transfer with no new accept clears win_valid_o.
  - Transfer and accept in the same cycle: win_valid_o reflects the new byte's window. Back-to-back windows at one per cycle are possible.
  - win_last_o is registered with win_valid_o and is meaningful only while win_valid_o=1.
- Stall: while win_valid_o=1 and win_ready_i=0, win_o and win_last_o hold and no byte is accepted.
- FSM states and transitions (evaluated only on an accepted byte):
  - IDLE:
    - sop_i=0: byte discarded (still accepted).
    - sop_i=1: cnt=1.
    - If STR_SIZE==1, the window becomes valid.
    - If eop_i also set: when STR_SIZE==1, window valid with last=1 and stay IDLE; otherwise short_cnt_o++ and stay IDLE.
    - Else go to FILL (or STREAM if STR_SIZE==1).
  - FILL:
    - cnt++.
    - If cnt reaches STR_SIZE: window valid; go to STREAM; or IDLE with last=1 if eop_i.
    - Else if eop_i: short_cnt_o++, cnt=0, go to IDLE.
  - STREAM:
    - Each byte produces a window.
    - On eop_i: last=1, go to IDLE.
  - Any state, sop_i=1 mid-string: the old string is abandoned, with no short count. Restart as in IDLE with cnt=1.
- short_cnt_o saturates at 2^CNT_W-1.
- The window register is not cleared between strings; only cnt gates validity, so stale bytes never surface.
- Reset mid-operation: asynchronous clear of all state. Any pending window is lost, with no partial output.

Decomposition:
- Shared package: STR_SIZE and BYTE_W defaults, and typedef str_window_t = logic [STR_SIZE-1:0][BYTE_W-1:0], used by both str_window and crc.
- One FSM state enum, local to the module.
- No sub-module is necessary. The shift register and FSM stay in str_window.
- The bench instantiates str_window -> crc to check hashes end to end.

Test Plan:
- String 1..6 (sop on 1, eop on 6), win_ready_i=1 -> one window {6,5,4,3,2,1} with last=1, 1 cycle after byte 6; short_cnt_o=0.
- String 1..8, STR_SIZE=6, win_ready_i=1 -> windows {6..1}, {7..2}, {8..3} on consecutive cycles; only the third has last=1.
- String 1,2,3 with eop on 3 -> no win_valid_o; short_cnt_o=1. Then 10..15 -> window {15..10}, unaffected by the stale bytes.
- Stream 1..8 with win_ready_i low for 3 cycles after the first window -> ready_o=0, window {6..1} held for 4 cycles, then {7..2} and {8..3}; no byte lost.
- Bytes 1..4 without sop, then sop 20..25 -> bytes 1..4 discarded; window {25..20}. sop mid-string at byte 3 of 30..35 -> restart; no short count.
- Assert rst_i while win_valid_o=1 mid-string -> all outputs 0 immediately; after release, string 1..6 gives {6..1} normally.
